elevator_controller: RTL
========================

Name: elevator_controller

Overview:
- Car-motion controller sitting directly downstream of the per-floor request latches.
- Consumes the latched request bits and moves the car one floor at a time using SCAN ordering (keep going while requests lie ahead, then reverse).
- Times the door at each serviced floor.
- Returns a one-cycle clear pulse per serviced floor that drives that floor's request-latch clear, closing the loop with the request registers.

Parameters:
- FLOORS, 4: number of floors; floor 0 is the bottom.
- FLOOR_W, 2: width of the floor index; must satisfy 2**FLOOR_W >= FLOORS.
- MOVE_CYCLES, 8: clock cycles to travel one floor; must be >= 1.
- DOOR_CYCLES, 16: clock cycles the door stays open per service; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- req  input  FLOORS  latched request bits, one per floor (level, from request registers).
- floor  output  FLOOR_W  current car floor.
- dir_up  output  1  1 = travelling/preferring up, 0 = down.
- moving  output  1  high while in MOVE_UP or MOVE_DOWN.
- door_open  output  1  high while in DOOR.
- req_clr  output  FLOORS  one-hot, one-cycle pulse clearing the serviced floor's request latch.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - clr_n low forces state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, req_clr=0, timer=0.
  - All outputs are registered.
  - Reset mid-move or mid-door aborts immediately; position is reinitialised to floor 0, by design.
- Derived terms, combinational from req and floor:
  - here = req[floor]
  - above = any req bit with index > floor
  - below = any req bit with index < floor
- IDLE evaluation, in priority order:
  - here: go to DOOR, pulse req_clr[floor], load door timer.
  - dir_up & above: go to MOVE_UP.
  - below: go to MOVE_DOWN, dir_up<=0.
  - above: go to MOVE_UP, dir_up<=1.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Entering loads timer=0; timer increments each cycle.
  - When timer==MOVE_CYCLES-1, floor<=floor±1 on that edge, i.e. the floor changes exactly MOVE_CYCLES cycles after entry.
  - The cycle after arrival, using the updated floor:
    - here: go to DOOR with req_clr pulse.
    - else requests remain ahead in the same direction: reload timer and keep moving.
    - else go to IDLE.
  - Floor never exceeds FLOORS-1 or goes below 0; MOVE_UP is only entered with above=1, MOVE_DOWN only with below=1.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
  - req_clr[floor] is high only on the first DOOR cycle.
  - req[floor] is ignored on that first cycle, because the latch clears asynchronously from the pulse.
  - req[floor] seen high on any later DOOR cycle (re-press): pulse req_clr[floor] again and restart the full DOOR_CYCLES count.
  - Requests at other floors are held until IDLE.
- Simultaneous events: a request at the current floor always wins over travel. Direction ties in IDLE follow the current dir_up.
- req_clr is never asserted outside DOOR and is always zero or one-hot.

Test Plan:
Bench parameters: FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3.
- Reset then req=0001 → IDLE→DOOR next edge; req_clr=0001 for 1 cycle; door_open high 3 cycles; back to IDLE; floor=0.
- From floor 0, req=1000 held → moving=1, dir_up=1; floor steps 1, 2, 3 at 4-cycle intervals with no stops; then DOOR with req_clr=1000.
- Car at floor 1 moving up toward floor 3, floor 0 pressed → continues up, services 3, then IDLE chooses down (dir_up=0) and services 0.
- req[2] pulsed again on the second cycle of a DOOR at floor 2 → second req_clr=0100 pulse; door_open stays high 3 further cycles; total 4.
- clr_n dropped mid-move at timer=2 while going 1→2 → outputs immediately floor=0, dir_up=1, moving=0, door_open=0, req_clr=0; resumes normal service after release.
- req=0101 at floor 0 with dir_up=1 → floor 0 serviced first; then moves up; stops at 2; then IDLE with req=0.

Source files
------------

// File: rtl/elevator_controller.sv
// SCAN-ordered car controller: steps one floor every MOVE_CYCLES, holds the door for
// DOOR_CYCLES per service and pulses req_clr once for each service of a floor.
module elevator_controller #(
  parameter int FLOORS      = 4,
  parameter int FLOOR_W     = 2,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  req_clr
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  state_e             state_q;
  logic [FLOOR_W-1:0] floor_q;
  logic               dir_up_q;
  logic               moving_q;
  logic               door_open_q;
  logic               arrived_q;
  logic [FLOORS-1:0]  req_clr_q;
  logic [TW-1:0]      timer_q;

  logic [FLOORS-1:0]  here_vec;
  logic [FLOORS-1:0]  above_vec;
  logic [FLOORS-1:0]  below_vec;
  logic [FLOORS-1:0]  floor_onehot;
  logic               here;
  logic               above;
  logic               below;
  logic               ahead;
  logic [FLOOR_W-1:0] floor_d;

  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_floor
      assign floor_onehot[gi] = (floor_q == FLOOR_W'(gi));
      assign here_vec[gi]     = req[gi] & floor_onehot[gi];
      assign above_vec[gi]    = req[gi] & (FLOOR_W'(gi) > floor_q);
      assign below_vec[gi]    = req[gi] & (FLOOR_W'(gi) < floor_q);
    end
  endgenerate

  always_comb begin
    here    = |here_vec;
    above   = |above_vec;
    below   = |below_vec;
    ahead   = (state_q == MOVE_DOWN) ? below : above;
    floor_d = (state_q == MOVE_DOWN) ? (floor_q - FLOOR_W'(1)) : (floor_q + FLOOR_W'(1));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      arrived_q   <= 1'b0;
      req_clr_q   <= '0;
      timer_q     <= '0;
    end else begin
      req_clr_q <= '0;
      arrived_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (here) begin
            state_q     <= DOOR;
            door_open_q <= 1'b1;
            req_clr_q   <= floor_onehot;
            timer_q     <= '0;
          end else if ((dir_up_q && above) || (!below && above)) begin
            state_q  <= MOVE_UP;
            dir_up_q <= 1'b1;
            moving_q <= 1'b1;
            timer_q  <= '0;
          end else if (below) begin
            state_q  <= MOVE_DOWN;
            dir_up_q <= 1'b0;
            moving_q <= 1'b1;
            timer_q  <= '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          // The arrival cycle also counts as the first cycle of the next leg.
          if (arrived_q && here) begin
            state_q     <= DOOR;
            moving_q    <= 1'b0;
            door_open_q <= 1'b1;
            req_clr_q   <= floor_onehot;
            timer_q     <= '0;
          end else if (arrived_q && !ahead) begin
            state_q  <= IDLE;
            moving_q <= 1'b0;
            timer_q  <= '0;
          end else if (timer_q == MOVE_LAST) begin
            floor_q   <= floor_d;
            arrived_q <= 1'b1;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DOOR: begin
          // req is stale while our own clear pulse is out; a re-press counts from this cycle.
          if ((req_clr_q == '0) && here) begin
            req_clr_q <= floor_onehot;
            timer_q   <= TW'(1);
          end else if (timer_q == DOOR_LAST) begin
            state_q     <= IDLE;
            door_open_q <= 1'b0;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign req_clr   = req_clr_q;

endmodule
